// File: rtl/cfg_write_scheduler_pkg.sv
// Shared definitions for the configuration write scheduler and the synth top.
package cfg_write_scheduler_pkg;

    localparam int NUM_BYTES  = 6;
    localparam int CFG_ADDR_W = 3;

    typedef enum logic {
        IDLE,
        COMMIT
    } state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_sel_t;

endpackage

// File: rtl/cfg_rr_arb.sv
// Two-requester round-robin arbiter; the parent gates grants with enable/FSM state.
module cfg_rr_arb
    import cfg_write_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant_a,
    output logic grant_b
);

    req_sel_t rr_last;

    // On a tie the requester that was not granted last wins.
    assign grant_a = req_a && (!req_b || rr_last == REQ_B);
    assign grant_b = req_b && !grant_a;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last <= REQ_B;
        end else if (advance && grant_a) begin
            rr_last <= REQ_A;
        end else if (advance && grant_b) begin
            rr_last <= REQ_B;
        end
    end

endmodule

// File: rtl/cfg_write_scheduler.sv
// Collects config writes into a shadow copy and drains changed bytes to the synth
// one per cycle at frame boundaries or on demand.
module cfg_write_scheduler
    import cfg_write_scheduler_pkg::*;
#(
    parameter int NUM_BYTES  = cfg_write_scheduler_pkg::NUM_BYTES,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [FRAME_BITS-1:0] frame_period,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [CFG_ADDR_W-1:0] a_addr,
    input  logic [7:0]            a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [CFG_ADDR_W-1:0] b_addr,
    input  logic [7:0]            b_data,
    input  logic                  commit_now,
    output logic [7:0]            cfg_data,
    output logic [7:0]            cfg_en,
    output logic                  frame_tick,
    output logic                  busy
);

    state_t                  state, state_nxt;
    logic [7:0]              shadow [NUM_BYTES];
    logic [NUM_BYTES-1:0]    dirty;
    logic [NUM_BYTES-1:0]    wr_mask;
    logic [NUM_BYTES-1:0]    sel_mask;
    logic [FRAME_BITS-1:0]   frame_cnt;
    logic                    active, drain, gnt_a, gnt_b, wr_fire;
    logic [CFG_ADDR_W-1:0]   wr_addr;
    logic [7:0]              wr_data;

    assign active = ena && (state == IDLE);
    assign drain  = ena && (state == COMMIT);
    assign busy   = (state == COMMIT);

    cfg_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .advance (active),
        .grant_a (gnt_a),
        .grant_b (gnt_b)
    );

    assign a_ready = active && gnt_a;
    assign b_ready = active && gnt_b;
    assign wr_fire = (a_valid && a_ready) || (b_valid && b_ready);
    assign wr_addr = a_ready ? a_addr : b_addr;
    assign wr_data = a_ready ? a_data : b_data;

    // Writes outside the managed range complete the handshake but touch nothing.
    always_comb begin
        wr_mask = '0;
        if (wr_fire && int'(wr_addr) < NUM_BYTES) begin
            wr_mask[wr_addr] = 1'b1;
        end
    end

    // The >= compare keeps the counter bounded when frame_period is lowered.
    assign frame_tick = ena && (frame_cnt >= frame_period);

    // Lowest set bit of dirty: x & -x.
    assign sel_mask = dirty & (~dirty + 1'b1);

    always_comb begin
        cfg_en   = '0;
        cfg_data = '0;
        if (drain) begin
            cfg_en[NUM_BYTES-1:0] = sel_mask;
            for (int i = 0; i < NUM_BYTES; i++) begin
                cfg_data = cfg_data | (shadow[i] & {8{sel_mask[i]}});
            end
        end
    end

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((frame_tick || commit_now) && (|(dirty | wr_mask))) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                if (drain && ((dirty & ~sel_mask) == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shadow array is reset because the synth expects all-zero config after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
            dirty     <= '0;
            for (int i = 0; i < NUM_BYTES; i++) begin
                shadow[i] <= '0;
            end
        end else if (ena) begin
            state     <= state_nxt;
            frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
            dirty     <= (dirty & ~(drain ? sel_mask : '0)) | wr_mask;
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_mask[i]) begin
                    shadow[i] <= wr_data;
                end
            end
        end
    end

endmodule
